// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enemy_pkg
// Description : Shared enemy definitions: dead-position code, row coordinates,
//               march phase encodings, sequencer FSM states and position
//               field slice constants.
// Revision    : 1.0 - initial release
// ============================================================================
package enemy_pkg;

    // Position code presented while an enemy is dead
    localparam logic [18:0] NONE = {19{1'b1}};

    // Position field slices: {x[18:9], y[8:0]}
    localparam int X_MSB = 18;
    localparam int X_LSB = 9;
    localparam int Y_MSB = 8;

    // Row coordinates (32-pixel row pitch)
    localparam logic [8:0] ROW0_Y = 9'd72;
    localparam logic [8:0] ROW1_Y = 9'd104;
    localparam logic [8:0] ROW2_Y = 9'd136;
    localparam logic [8:0] ROW3_Y = 9'd168;
    localparam logic [8:0] ROW4_Y = 9'd200;

    // March phases: L = step left, R = step right
    localparam logic [1:0] PH_L0 = 2'b00;
    localparam logic [1:0] PH_R0 = 2'b01;
    localparam logic [1:0] PH_R1 = 2'b10;
    localparam logic [1:0] PH_L1 = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_DEAD  = 2'd2
    } march_state_t;

    // Extract the horizontal field of a packed position
    function automatic logic [9:0] pos_x(input logic [18:0] pos);
        return pos[X_MSB:X_LSB];
    endfunction

    // Extract the vertical field of a packed position
    function automatic logic [8:0] pos_y(input logic [18:0] pos);
        return pos[Y_MSB:0];
    endfunction

endpackage : enemy_pkg
`default_nettype wire

// File: rtl/enemy_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : enemy_tick_divider
// Description : Free-running step divider. Counts enabled cycles and raises a
//               terminal-count pulse on the last cycle of each period. Clear
//               has priority over enable and returns the count to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_tick_divider #(
    parameter int                TICK_W         = 24,
    parameter logic [TICK_W-1:0] TICKS_PER_STEP = 24'd500_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_En,
    input  logic i_Clr,
    output logic o_Tc
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICKS_PER_STEP - TICK_W'(1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              w_last;

    assign w_last = (tick_q == LAST_TICK);
    // Pulse only on an enabled cycle so a held count never re-fires
    assign o_Tc   = i_En && !i_Clr && w_last;

    // Next count: clear wins, wrap at the terminal count, otherwise advance
    always_comb begin
        tick_d = tick_q;
        if (i_Clr) begin
            tick_d = '0;
        end else if (i_En) begin
            tick_d = w_last ? '0 : tick_q + TICK_W'(1);
        end
    end

    // Tick counter register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule : enemy_tick_divider
`default_nettype wire

// File: rtl/enemy_march_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : enemy_march_sequencer
// Description : Holds one enemy's position, alive flag and march phase. On
//               each divider step it captures the move stage's next position
//               and advances the phase every STEPS_PER_PHASE steps.
//               Optional macro ENEMY_MARCH_PAUSE_EN adds i_Pause, which
//               freezes the march counters and phase while asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_march_sequencer
    import enemy_pkg::*;
#(
    parameter int                TICK_W            = 24,
    parameter logic [TICK_W-1:0] TICKS_PER_STEP    = 24'd500_000,
    parameter logic [5:0]        STEPS_PER_PHASE   = 6'd32,
    parameter logic [9:0]        INIT_X            = 10'd320,
    parameter logic [8:0]        VERTICAL_POSITION = 9'd168
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic        i_Kill,
    input  logic        i_Respawn,
`ifdef ENEMY_MARCH_PAUSE_EN
    input  logic        i_Pause,
`endif
    input  logic [18:0] i_NextPosition,
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic [1:0]  o_PhaseState,
    output logic        o_MoveStrobe
);

    localparam logic [18:0] INIT_POS  = {INIT_X, VERTICAL_POSITION};
    localparam logic [5:0]  LAST_STEP = STEPS_PER_PHASE - 6'd1;

    march_state_t state_q, state_d;
    logic [18:0]  pos_q, pos_d;
    logic [1:0]   phase_q, phase_d;
    logic [5:0]   step_q, step_d;

    logic w_pause;
    logic w_march;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_step;

`ifdef ENEMY_MARCH_PAUSE_EN
    assign w_pause = i_Pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_march    = (state_q == ST_MARCH);
    // A kill suppresses the step and clears the partial tick count
    assign w_tick_en  = w_march && !w_pause && !i_Kill;
    assign w_tick_clr = !w_march || i_Kill;

    enemy_tick_divider #(
        .TICK_W         (TICK_W),
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_tick_divider (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_En  (w_tick_en),
        .i_Clr (w_tick_clr),
        .o_Tc  (w_step)
    );

    assign o_EnemyState    = (state_q != ST_DEAD);
    assign o_EnemyPosition = pos_q;
    assign o_PhaseState    = phase_q;
    assign o_MoveStrobe    = w_step;

    // Next-state, position capture and phase/step advance
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Kill) begin
                    state_d = ST_DEAD;
                    pos_d   = NONE;
                    phase_d = PH_L0;
                    step_d  = '0;
                end else if (i_Start) begin
                    state_d = ST_MARCH;
                end
            end
            ST_MARCH: begin
                if (i_Kill) begin
                    state_d = ST_DEAD;
                    pos_d   = NONE;
                    phase_d = PH_L0;
                    step_d  = '0;
                end else if (w_step) begin
                    pos_d = i_NextPosition;
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        phase_d = phase_q + 2'd1;
                    end else begin
                        step_d  = step_q + 6'd1;
                    end
                end
            end
            ST_DEAD: begin
                pos_d   = NONE;
                phase_d = PH_L0;
                step_d  = '0;
                // Respawn takes priority over a coincident kill
                if (i_Respawn) begin
                    state_d = ST_IDLE;
                    pos_d   = INIT_POS;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = INIT_POS;
                phase_d = PH_L0;
                step_d  = '0;
            end
        endcase
    end

    // State, position, phase and step registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            pos_q   <= INIT_POS;
            phase_q <= PH_L0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

endmodule : enemy_march_sequencer
`default_nettype wire
